// File: rtl/regfile_pkg.sv
// Shared defaults and sweep FSM state for the parameterised register file.
package regfile_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NREAD = 2;

  typedef enum logic {IDLE, CLEAR} rf_state_t;
endpackage

// File: rtl/regfile_read_port.sv
// One registered read port; with REGFILE_BYPASS_EN a same-cycle write to the
// addressed register is forwarded into the output register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             re,
  input  logic [WIDTH-1:0] rdata,
`ifdef REGFILE_BYPASS_EN
  input  logic [AW-1:0]    ra,
  input  logic             wr_acc,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
`endif
  output logic [WIDTH-1:0] rd
);
  logic [WIDTH-1:0] nxt;

`ifdef REGFILE_BYPASS_EN
  // wr_acc already excludes address 0 and out-of-range writes
  assign nxt = (wr_acc && (ra == wa)) ? wd : rdata;
`else
  assign nxt = rdata;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rd <= '0;
    else if (re) rd <= nxt;
  end
endmodule

// File: rtl/param_register_file.sv
// Multi-read-port register file with pending-write scoreboard and a one
// register per cycle clear sweep. Optional write-to-read bypass: REGFILE_BYPASS_EN.
module param_register_file
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int NREAD = DEF_NREAD,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD-1:0]       re,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic [NREAD-1:0]       busy,
  input  logic                   clr_req,
  output logic                   clr_busy
);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

  // Register 0 is hardwired: it is never a legal target or busy source.
  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_W);
  endfunction

  rf_state_t        state;
  logic [AW-1:0]    clr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] sb;

  logic wr_acc, rsv_acc, clr_start, clr_last;

  assign wr_acc    = we && (state == IDLE) && valid_addr(wa);
  assign rsv_acc   = rsv_en && (state == IDLE) && valid_addr(rsv_addr);
  assign clr_start = clr_req && (state == IDLE);
  assign clr_last  = (clr_ptr == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clr_ptr  <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clr_req) begin
          state    <= CLEAR;
          clr_ptr  <= AW'(1);
          clr_busy <= 1'b1;
        end
        CLEAR: if (clr_last) begin
          state    <= IDLE;
          clr_ptr  <= '0;
          clr_busy <= 1'b0;
        end else begin
          clr_ptr  <= clr_ptr + AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc) begin
      mem[wa] <= wd;
    end
  end

  // Reserve is applied after the write clear so a coinciding reserve wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb <= '0;
    end else if (clr_start) begin
      sb <= '0;
    end else if (state == IDLE) begin
      if (wr_acc)  sb[wa]       <= 1'b0;
      if (rsv_acc) sb[rsv_addr] <= 1'b1;
    end
  end

  logic [NREAD-1:0][AW-1:0]    ra_v;
  logic [NREAD-1:0][WIDTH-1:0] rdata_v, rd_v;

  assign ra_v = ra;
  assign rd   = rd_v;

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
    assign rdata_v[gi] = valid_addr(ra_v[gi]) ? mem[ra_v[gi]] : '0;
    assign busy[gi]    = valid_addr(ra_v[gi]) && sb[ra_v[gi]];

    regfile_read_port #(.WIDTH(WIDTH), .AW(AW)) u_port (
      .clock  (clock),
      .reset  (reset),
      .re     (re[gi]),
      .rdata  (rdata_v[gi]),
`ifdef REGFILE_BYPASS_EN
      .ra     (ra_v[gi]),
      .wr_acc (wr_acc),
      .wa     (wa),
      .wd     (wd),
`endif
      .rd     (rd_v[gi])
    );
  end
endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench: vector table with rd scoreboard, clear sweep, reset
// abort mid-sweep, and out-of-range handling on a non-power-of-two instance.
module tb_param_register_file;
  localparam int D = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        we, rsv_en, clr_req, clr_busy;
  logic [4:0]  wa, rsv_addr;
  logic [31:0] wd;
  logic [1:0]  re, busy;
  logic [9:0]  ra;
  logic [63:0] rd;

  logic        s_we, s_rsv_en, s_clr_req, s_clr_busy;
  logic [4:0]  s_wa, s_rsv_addr, s_ra;
  logic [7:0]  s_wd, s_rd;
  logic [0:0]  s_re, s_busy;

  param_register_file #(.WIDTH(32), .DEPTH(32), .NREAD(2)) dut (
    .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra),
    .rd(rd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  param_register_file #(.WIDTH(8), .DEPTH(20), .NREAD(1)) u_small (
    .clock(clock), .reset(reset), .we(s_we), .wa(s_wa), .wd(s_wd), .re(s_re),
    .ra(s_ra), .rd(s_rd), .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
    .busy(s_busy), .clr_req(s_clr_req), .clr_busy(s_clr_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m [D];
  logic [31:0] held [2];
  logic [31:0] q [$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        rsv;
    logic [4:0]  raddr;
    logic [1:0]  exp_busy;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %h expected <queue empty>", name, act);
    end else begin
      e = q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic fill_regs(input logic [31:0] base);
    re = 2'b00;
    for (int a = 1; a < D; a++) begin
      we = 1'b1; wa = 5'(a); wd = base + 32'(a) * 32'h0101_0101;
      cycle();
      m[a] = base + 32'(a) * 32'h0101_0101;
    end
    we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 1; a < D; a++) begin
      re = 2'b11; ra = {5'(D - a), 5'(a)};
      #1;
      check({tag, "_busy"}, {30'd0, busy}, 32'd0);
      cycle();
      check({tag, "_rd0"}, rd[31:0], 32'd0);
      check({tag, "_rd1"}, rd[63:32], 32'd0);
    end
    re = 2'b00;
  endtask

  initial begin
    logic [4:0]  rp [2];
    logic [31:0] e;
    logic        acc;
    int          n;

    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  2'b00};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  1'b0, 5'd0,  2'b00};
    tbl[2]  = '{1'b1, 5'd0,  32'h1234,     2'b11, 5'd0,  5'd5,  1'b0, 5'd0,  2'b00};
    tbl[3]  = '{1'b1, 5'd7,  32'hA5A5,     2'b11, 5'd7,  5'd5,  1'b0, 5'd0,  2'b00};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd7,  5'd0,  1'b0, 5'd0,  2'b00};
    tbl[5]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 2'b01, 5'd31, 5'd7,  1'b0, 5'd0,  2'b00};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd31, 5'd31, 1'b0, 5'd0,  2'b00};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd9,  5'd9,  1'b1, 5'd9,  2'b00};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd9,  5'd9,  1'b0, 5'd0,  2'b11};
    tbl[9]  = '{1'b1, 5'd9,  32'h99,       2'b01, 5'd9,  5'd5,  1'b0, 5'd0,  2'b01};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd9,  5'd9,  1'b0, 5'd0,  2'b00};
    tbl[11] = '{1'b1, 5'd9,  32'h77,       2'b01, 5'd9,  5'd9,  1'b1, 5'd9,  2'b00};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd9,  5'd0,  1'b0, 5'd0,  2'b01};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd0,  5'd9,  1'b1, 5'd0,  2'b10};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd9,  1'b0, 5'd0,  2'b10};
    tbl[15] = '{1'b1, 5'd12, 32'hC0FFEE,   2'b11, 5'd12, 5'd12, 1'b1, 5'd12, 2'b00};
    tbl[16] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd12, 5'd12, 1'b0, 5'd0,  2'b11};

    we = 0; wa = 0; wd = 0; re = 0; ra = 0; rsv_en = 0; rsv_addr = 0; clr_req = 0;
    s_we = 0; s_wa = 0; s_wd = 0; s_re = 0; s_ra = 0; s_rsv_en = 0; s_rsv_addr = 0; s_clr_req = 0;
    for (int a = 0; a < D; a++) m[a] = '0;
    held[0] = '0; held[1] = '0;

    #2 reset = 1'b0;
    #1;
    check("reset_rd0", rd[31:0], 32'd0);
    check("reset_rd1", rd[63:32], 32'd0);
    check("reset_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("reset_busy", {30'd0, busy}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Vector table with rd expectations queued at drive time
    for (int i = 0; i < 17; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; re = tbl[i].re;
      ra = {tbl[i].ra1, tbl[i].ra0}; rsv_en = tbl[i].rsv; rsv_addr = tbl[i].raddr;
      #1;
      check($sformatf("v%0d_busy", i), {30'd0, busy}, {30'd0, tbl[i].exp_busy});
      acc = tbl[i].we && (tbl[i].wa != 5'd0);
      rp[0] = tbl[i].ra0; rp[1] = tbl[i].ra1;
      for (int p = 0; p < 2; p++) begin
        if (tbl[i].re[p]) begin
          e = (BYP && acc && rp[p] == tbl[i].wa) ? tbl[i].wd : m[rp[p]];
          held[p] = e;
        end
        q.push_back(held[p]);
      end
      cycle();
      if (acc) m[tbl[i].wa] = tbl[i].wd;
      pop_check($sformatf("v%0d_rd0", i), rd[31:0]);
      pop_check($sformatf("v%0d_rd1", i), rd[63:32]);
    end
    we = 0; rsv_en = 0; re = 0;

    // Out-of-range writes/reads/reserves on the DEPTH=20 instance
    s_we = 1; s_wa = 5'd25; s_wd = 8'hAA; cycle();
    s_wa = 5'd19; s_wd = 8'h55; cycle();
    s_we = 0; s_rsv_en = 1; s_rsv_addr = 5'd25; cycle();
    s_rsv_addr = 5'd19; cycle();
    s_rsv_en = 0; s_re = 1'b1; s_ra = 5'd25;
    #1 check("oor_busy", {31'd0, s_busy}, 32'd0);
    cycle();
    check("oor_rd", {24'd0, s_rd}, 32'd0);
    s_ra = 5'd19;
    #1 check("top_busy", {31'd0, s_busy}, 32'd1);
    cycle();
    check("top_rd", {24'd0, s_rd}, 32'h55);
    s_re = 0;

    // Clear sweep with writes, reserves and clr_req held during it
    fill_regs(32'h1000_0001);
    rsv_en = 1; rsv_addr = 5'd3; cycle();
    rsv_addr = 5'd20; cycle();
    rsv_en = 0; ra = {5'd20, 5'd3};
    #1 check("pre_clr_busy", {30'd0, busy}, 32'd3);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    check("clr_sb_cleared", {30'd0, busy}, 32'd0);
    we = 1; wa = 5'd31; wd = 32'h5555; rsv_en = 1; rsv_addr = 5'd4; clr_req = 1;
    ra = {5'd4, 5'd31};
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      re = (n == 2) ? 2'b01 : 2'b00;
      if (n == 3) check("mid_sweep_read", rd[31:0], m[31]);
      cycle();
    end
    we = 0; rsv_en = 0; clr_req = 0; re = 0;
    check("clr_busy_cycles", 32'(n), 32'd31);
    #1 check("post_clr_rsv_ignored", {31'd0, busy[1]}, 32'd0);
    for (int a = 0; a < D; a++) m[a] = '0;
    check_all_zero("post_clr");

    // Reset abort at sweep cycle 10
    fill_regs(32'h2000_0003);
    re = 2'b11; ra = {5'd30, 5'd31}; cycle(); re = 2'b00;
    check("pre_abort_rd0", rd[31:0], m[31]);
    clr_req = 1'b1; cycle(); clr_req = 1'b0;
    repeat (9) cycle();
    check("abort_busy_before", {31'd0, clr_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("abort_rd0", rd[31:0], 32'd0);
    check("abort_rd1", rd[63:32], 32'd0);
    #3 reset = 1'b1;
    cycle();
    check("abort_idle", {31'd0, clr_busy}, 32'd0);
    for (int a = 0; a < D; a++) m[a] = '0;
    check_all_zero("abort");
    we = 1; wa = 5'd6; wd = 32'h0BAD_F00D; cycle();
    we = 0; re = 2'b01; ra = {5'd0, 5'd6}; cycle(); re = 0;
    check("abort_write_ok", rd[31:0], 32'h0BAD_F00D);
    check("abort_still_idle", {31'd0, clr_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, register count; range 2..256; AW = $clog2(DEPTH).
REQ-003 Parameter NREAD, default 2, read-port count; range 1..4.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 we  in  1  write enable.
REQ-007 wa  in  AW  write address.
REQ-008 wd  in  WIDTH  write data.
REQ-009 re  in  NREAD  per-port read enable.
REQ-010 ra  in  NREAD*AW  packed read addresses; port i uses slice i.
REQ-011 rd  out  NREAD*WIDTH  packed registered read data.
REQ-012 rsv_en  in  1  scoreboard reserve strobe.
REQ-013 rsv_addr  in  AW  address to mark pending.
REQ-014 busy  out  NREAD  combinational scoreboard bit of ra slice i.
REQ-015 clr_req  in  1  one-cycle pulse starting a clear sweep.
REQ-016 clr_busy  out  1  high while the sweep runs.

Function
REQ-017 Register 0 SHALL always read zero, ignore writes and never report busy.
REQ-018 Write: when we=1, clr_busy=0 and 0<wa<DEPTH, reg[wa] SHALL take wd at the edge.
REQ-019 Writes with wa>=DEPTH SHALL be ignored; reads with ra>=DEPTH SHALL return zero.
REQ-020 Read latency SHALL be 1 cycle: rd slice i loads reg[ra_i] at the edge when re[i]=1 and holds otherwise.
REQ-021 Ports SHALL be independent; equal addresses on several ports SHALL return identical data.
REQ-022 Scoreboard: rsv_en=1 SHALL set sb[rsv_addr]; an accepted write SHALL clear sb[wa].
REQ-023 Reserve and accepted write to the same address in one cycle SHALL leave sb set (set wins).
REQ-024 busy[i] SHALL equal sb[ra_i] with no delay; zero for address 0 or out-of-range.
REQ-025 FSM states: IDLE, CLEAR. IDLE->CLEAR on clr_req; CLEAR->IDLE after writing address DEPTH-1.
REQ-026 In CLEAR, one register per cycle SHALL be zeroed, ascending from 1; the sweep takes DEPTH-1 cycles.
REQ-027 On the IDLE->CLEAR edge all scoreboard bits SHALL be cleared.
REQ-028 clr_busy SHALL be high exactly while in CLEAR; we and rsv_en SHALL be ignored then.
REQ-029 clr_req SHALL be ignored while in CLEAR; reads stay legal and return current contents.

Reset
REQ-030 reset low SHALL immediately zero all registers, rd, scoreboard and sweep counter, and force IDLE.
REQ-031 reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be IDLE with clr_busy=0.

Configuration
REQ-032 With REGFILE_BYPASS_EN defined, a read with re[i]=1 and ra_i==wa coinciding with an accepted write (wa!=0) SHALL load wd into rd slice i.
REQ-033 Without REGFILE_BYPASS_EN, such a read SHALL load the pre-write contents of reg[wa].

Structure
REQ-034 Package regfile_pkg SHALL hold default WIDTH/DEPTH/NREAD constants and the FSM state enum.
REQ-035 Sub-module regfile_read_port SHALL implement one registered read port including the bypass compare; it is instantiated NREAD times.

Verification
REQ-036 Write 32'hDEADBEEF to addr 5, next cycle read port 0 addr 5 -> rd0=32'hDEADBEEF one cycle later.
REQ-037 Write 32'h1234 to addr 0, read addr 0 -> rd0=0, busy0=0.
REQ-038 Same-cycle write 32'hA5A5 to addr 7 with read addr 7 -> rd0=32'hA5A5 with REGFILE_BYPASS_EN, old value (0 after reset) without.
REQ-039 rsv_en addr 9 -> busy=1 while ra0=9; write addr 9 -> busy0=0 next cycle; reserve+write addr 9 together -> busy0 stays 1.
REQ-040 Fill regs 1..31 with nonzero values, pulse clr_req -> clr_busy high 31 cycles, we ignored, all regs read 0 afterward, scoreboard empty.
REQ-041 Assert reset low at sweep cycle 10 -> clr_busy=0 immediately, all regs 0, FSM IDLE after release.
